divider: RTL
============

Name: divider

Overview:
- Iterative 16-bit integer divider. It is the inverse companion to the ALU's single-cycle multiply.
- Sits beside the ALU in the CPU datapath. The control unit issues a start pulse and stalls on busy until done.
- Produces quotient and remainder, signed or unsigned, one quotient bit per clock using the restoring algorithm.

Parameters:
WIDTH, 16, operand/result width in bits (CPU word size)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
signed_op  input  1  1 = two's-complement division, 0 = unsigned; latched with start
a  input  WIDTH  dividend, latched at accepted start
b  input  WIDTH  divisor, latched at accepted start
busy  output  1  high while state is CALC or FIX
done  output  1  one-cycle pulse; quot/rem/div_zero valid from this cycle on
quot  output  WIDTH  quotient
rem  output  WIDTH  remainder
div_zero  output  1  last accepted operation had b == 0

Behaviour:
- Reset: state IDLE; busy, done, div_zero, quot and rem are all 0. rst mid-operation aborts immediately, produces no done pulse, and zeroes the outputs.
- States:
  - IDLE: wait for start.
  - CALC: 16 iterations.
  - FIX: sign correction.
  - DONE: single cycle, then IDLE, unless a new start is accepted.
- Accept edge E0: start=1 while in IDLE or DONE.
  - Latch a, b and signed_op.
  - If b==0: go to DONE. quot=all-ones, rem=a, div_zero=1. done is high in the cycle right after E0.
  - Otherwise: go to CALC with div_zero=0.
- Operand preparation at E0: if signed_op, take |a| and |b|, and record neg_q = a[15]^b[15] and neg_r = a[15]. Unsigned operations set both flags to 0.
- CALC, one iteration per edge E1..E16:
  - Shift partial remainder left by 1 and bring in the next dividend MSB.
  - Trial-subtract the divisor on a 17-bit path. If non-negative, keep the difference and set quotient bit 1. Otherwise restore and set the bit to 0.
  - At E16 go to FIX.
- FIX, edge E17: negate quot if neg_q and negate rem if neg_r. The result truncates toward zero, and the remainder takes the sign of the dividend. Then go to DONE.
- Timing: done is high in the cycle following E17, a fixed latency of 17 edges for nonzero b. busy is high in cycles after E0 through E16, i.e. while in CALC or FIX.
- Signed overflow: 0x8000 / 0xFFFF gives quot=0x8000, rem=0x0000. This is the natural wrap; no flag is raised.
- start while busy is ignored, with no effect on the latched operands or progress.
- start during DONE is accepted (back-to-back operation). done still pulses in that cycle, and the next operation proceeds normally.
- quot/rem/div_zero hold their value from done until the next accepted start. During CALC/FIX, quot/rem are undefined-but-stable internal values; consumers must use them only at or after done.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package cpu_pkg:
  - localparam WORD_WIDTH = 16.
  - enum div_state_t {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE}.
  - ALU/div opcode constants (DIVU, DIVS, REMU, REMS) used by the decoder.
- One sub-module is natural: div_step. It is combinational: one restoring iteration taking remainder, dividend bit and divisor, and returning the next remainder and quotient bit.
- The top level holds the FSM, counter, operand registers and sign fixup.

Test Plan:
1. Unsigned: a=0xDEAD, b=0x0010, signed_op=0, start at E0 -> done in cycle after E17, quot=0x0DEA, rem=0x000D, div_zero=0; busy high for exactly 17 cycles.
2. Signed: a=0xFFF9 (-7), b=0x0002, signed_op=1 -> quot=0xFFFD (-3), rem=0xFFFF (-1). Also a=0x0007, b=0xFFFE -> quot=0xFFFD, rem=0x0001.
3. Divide by zero: a=0x1234, b=0x0000 -> done in cycle after E0, quot=0xFFFF, rem=0x1234, div_zero=1, busy never high.
4. Signed overflow: a=0x8000, b=0xFFFF, signed_op=1 -> quot=0x8000, rem=0x0000, div_zero=0.
5. Protocol:
   - Second start with a=0x0001, b=0x0001 at E0+5 -> ignored; result is still op 1's (0x0DEA/0x000D).
   - Separate run with rst at E0+5 -> busy=0 next cycle, no done, quot=rem=0.
6. Back-to-back: start in op 1's done cycle with a=0xBEEF, b=0x00FF unsigned -> second done 17 edges later, quot=0x00BF, rem=0x00AE; op 1 outputs hold until that accept.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, divider FSM states and the
// decoder's divide/remainder opcode encodings.
package cpu_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  // Opcode encodings the decoder uses to route work to the divider.
  localparam logic [3:0] DIVU = 4'h8;
  localparam logic [3:0] DIVS = 4'h9;
  localparam logic [3:0] REMU = 4'hA;
  localparam logic [3:0] REMS = 4'hB;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational: shift in the next
// dividend bit, trial-subtract the divisor, and keep the difference or restore.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    shifted          = {rem_i, bit_i};
    {borrow, diff}   = {1'b0, shifted} - {2'b00, divisor_i};
    q_o              = ~borrow;
    // A successful subtract always leaves a value below the divisor, so the
    // low WIDTH bits hold the whole result in either branch.
    rem_o            = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider, signed or unsigned; 17 edges from accept to done
// (1 for divide-by-zero). start is ignored while busy; results hold until the next accept.
module divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] qd_q, qd_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign a_abs = (signed_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign b_abs = (signed_op && b[WIDTH-1]) ? WIDTH'(-b) : b;

  // qd_q starts as |a| and, as dividend bits leave at the top, quotient bits
  // enter at the bottom; after WIDTH iterations it holds the magnitude quotient.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (pr_q),
    .bit_i    (qd_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvs_d      = dvs_q;
    pr_d       = pr_q;
    qd_d       = qd_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
        if (start) begin
          dvs_d   = b_abs;
          qd_d    = a_abs;
          pr_d    = '0;
          cnt_d   = '0;
          neg_q_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = signed_op & a[WIDTH-1];
          if (b == '0) begin
            state_d    = DIV_DONE;
            quot_d     = '1;
            rem_d      = a;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d    = DIV_CALC;
            div_zero_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end

      DIV_CALC: begin
        pr_d  = step_rem;
        qd_d  = {qd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        // Truncating division: quotient sign from the operand signs,
        // remainder sign follows the dividend.
        quot_d  = neg_q_q ? WIDTH'(-qd_q) : qd_q;
        rem_d   = neg_r_q ? WIDTH'(-pr_q) : pr_q;
        state_d = DIV_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      dvs_q      <= '0;
      pr_q       <= '0;
      qd_q       <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvs_q      <= dvs_d;
      pr_q       <= pr_d;
      qd_q       <= qd_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;

endmodule
